// File: rtl/chain_dump_pkg.sv
// Shared definitions for the shadow-chain dump collector: FSM state encoding,
// channel-index width helper and the FIFO entry layout {last, ch, data}.
package chain_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_DUMP = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // FIFO entry = {last, ch[ch_w-1:0], data[word_w-1:0]}
    function automatic int unsigned entry_width(input int unsigned word_w,
                                                input int unsigned ch_w);
        return word_w + ch_w + 1;
    endfunction

endpackage

// File: rtl/chain_dump_fifo.sv
// Synchronous FIFO for deserialized dump words. A push onto a full FIFO is
// dropped and flagged, except when a pop happens in the same cycle.
// Output data reads as zero while empty.
module chain_dump_fifo #(
    parameter int unsigned WIDTH = 39,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/chain_dump_collector.sv
// Shadow-chain dump collector: sweeps dump_en across the masked chains,
// deserializes each chain's serial stream into WORD_W words (first bit in
// bit 0) and queues them for the host with a valid/ready handshake.
// Optional feature macro: DUMP_BITCNT_EN appends a per-channel bit-count
// trailer word carrying the last flag.
module chain_dump_collector
    import chain_dump_pkg::*;
#(
    parameter int unsigned NUM_CH     = 64,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TO_CYCLES  = 1024
) (
    input  logic                          sh_clk,
    input  logic                          sh_rst,
    input  logic                          start,
    input  logic [NUM_CH-1:0]             ch_mask,
    output logic [NUM_CH-1:0]             dump_en,
    input  logic [NUM_CH-1:0]             ch_out,
    input  logic [NUM_CH-1:0]             ch_out_vld,
    input  logic [NUM_CH-1:0]             ch_out_done,
    output logic                          wd_vld,
    input  logic                          wd_rdy,
    output logic [WORD_W-1:0]             wd_data,
    output logic [ch_width(NUM_CH)-1:0]   wd_ch,
    output logic                          wd_last,
    output logic                          busy,
    output logic                          ovf_err,
    output logic                          to_err
);

    localparam int unsigned CH_W  = ch_width(NUM_CH);
    localparam int unsigned ENT_W = entry_width(WORD_W, CH_W);
    localparam int unsigned CW    = $clog2(WORD_W) + 1;
    localparam int unsigned TW    = $clog2(TO_CYCLES) + 1;
`ifdef DUMP_BITCNT_EN
    localparam bit BITCNT = 1'b1;
`else
    localparam bit BITCNT = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [CH_W-1:0]     ch_q, ch_d, pick;
    logic [WORD_W-1:0]   sh_q, sh_d, tot_q, tot_d, word;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_n;
    logic [TW-1:0]       to_q, to_d;
    logic                pushed_q, pushed_d;
    logic                to_err_q, to_err_d, ovf_err_q;
    logic                bit_vld, bit_d, bit_done, full_word, idle, tmo, fin;
    logic                push, push_last, pop, fifo_empty, fifo_drop;
    logic [WORD_W-1:0]   push_data;
    logic [ENT_W-1:0]    rd_ent;

    assign bit_vld  = ch_out_vld[ch_q];
    assign bit_d    = ch_out[ch_q];
    assign bit_done = ch_out_done[ch_q];

    // FSM next state, channel picker, deserializer and timeout next-state.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ch_d      = ch_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        tot_d     = tot_q;
        to_d      = to_q;
        pushed_d  = pushed_q;
        to_err_d  = to_err_q;
        push      = 1'b0;
        push_last = 1'b0;
        push_data = '0;
        dump_en   = '0;
        pick      = '0;
        word      = sh_q;
        cnt_n     = cnt_q;
        full_word = 1'b0;
        idle      = 1'b0;
        tmo       = 1'b0;
        fin       = 1'b0;

        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (pend_q[i-1]) pick = CH_W'(i-1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !busy) begin
                    pend_d  = ch_mask;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (pend_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d         = pick;
                    pend_d[pick] = 1'b0;
                    sh_d         = '0;
                    cnt_d        = '0;
                    tot_d        = '0;
                    to_d         = '0;
                    pushed_d     = 1'b0;
                    state_d      = ST_DUMP;
                end
            end
            ST_DUMP: begin
                dump_en[ch_q] = 1'b1;
                // Capture the incoming bit before any done/timeout flush.
                for (int unsigned i = 0; i < WORD_W; i++) begin
                    if (bit_vld && cnt_q == CW'(i)) word[i] = bit_d;
                end
                cnt_n     = cnt_q + CW'(bit_vld);
                full_word = bit_vld && (cnt_q == CW'(WORD_W - 1));
                idle      = !bit_vld && !bit_done;
                tmo       = idle && (to_q == TW'(TO_CYCLES - 1));
                fin       = bit_done || tmo;
                to_d      = idle ? to_q + TW'(1) : '0;
                if (bit_vld && tot_q != '1) tot_d = tot_q + WORD_W'(1);
                if (tmo) to_err_d = 1'b1;
                sh_d  = word;
                cnt_d = cnt_n;
                if (full_word) begin
                    push      = 1'b1;
                    push_data = word;
                    push_last = fin && !BITCNT;
                    pushed_d  = 1'b1;
                    sh_d      = '0;
                    cnt_d     = '0;
                end else if (fin && (cnt_n != '0 || !pushed_q)) begin
                    // Partial word is already zero above cnt; an empty
                    // channel yields an all-zero word here.
                    push      = 1'b1;
                    push_data = word;
                    push_last = !BITCNT;
                    pushed_d  = 1'b1;
                end
                if (fin) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (BITCNT) begin
                    push      = 1'b1;
                    push_data = tot_q;
                    push_last = 1'b1;
                end
                state_d = ST_SEL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge sh_clk) begin
        if (sh_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers and sticky error flags.
    always_ff @(posedge sh_clk) begin
        if (sh_rst) begin
            pend_q    <= '0;
            ch_q      <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            tot_q     <= '0;
            to_q      <= '0;
            pushed_q  <= 1'b0;
            to_err_q  <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            ch_q      <= ch_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            tot_q     <= tot_d;
            to_q      <= to_d;
            pushed_q  <= pushed_d;
            to_err_q  <= to_err_d;
            ovf_err_q <= ovf_err_q | fifo_drop;
        end
    end

    assign pop = wd_vld && wd_rdy;

    chain_dump_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sh_clk),
        .rst_i   (sh_rst),
        .push_i  (push),
        .data_i  ({push_last, ch_q, push_data}),
        .pop_i   (pop),
        .data_o  (rd_ent),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign wd_vld  = !fifo_empty;
    assign wd_data = rd_ent[WORD_W-1:0];
    assign wd_ch   = rd_ent[WORD_W +: CH_W];
    assign wd_last = rd_ent[ENT_W-1];
    assign busy    = (state_q != ST_IDLE) || !fifo_empty;
    assign ovf_err = ovf_err_q;
    assign to_err  = to_err_q;

endmodule

// File: tb/tb_chain_dump_collector.sv
// Directed testbench for chain_dump_collector (default parameters).
// Builds with or without DUMP_BITCNT_EN; expectations follow the build.
module tb_chain_dump_collector;

    localparam int unsigned NUM_CH     = 64;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned TO_CYCLES  = 1024;
    localparam int unsigned CH_W       = 6;

    logic              sh_clk = 1'b0;
    logic              sh_rst;
    logic              start;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] dump_en;
    logic [NUM_CH-1:0] ch_out;
    logic [NUM_CH-1:0] ch_out_vld;
    logic [NUM_CH-1:0] ch_out_done;
    logic              wd_vld;
    logic              wd_rdy;
    logic [WORD_W-1:0] wd_data;
    logic [CH_W-1:0]   wd_ch;
    logic              wd_last;
    logic              busy;
    logic              ovf_err;
    logic              to_err;

    int n_checks = 0;
    int n_fails  = 0;
    logic [63:0] got[$];

    always #5 sh_clk = ~sh_clk;

    chain_dump_collector #(
        .NUM_CH     (NUM_CH),
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TO_CYCLES  (TO_CYCLES)
    ) dut (
        .sh_clk      (sh_clk),
        .sh_rst      (sh_rst),
        .start       (start),
        .ch_mask     (ch_mask),
        .dump_en     (dump_en),
        .ch_out      (ch_out),
        .ch_out_vld  (ch_out_vld),
        .ch_out_done (ch_out_done),
        .wd_vld      (wd_vld),
        .wd_rdy      (wd_rdy),
        .wd_data     (wd_data),
        .wd_ch       (wd_ch),
        .wd_last     (wd_last),
        .busy        (busy),
        .ovf_err     (ovf_err),
        .to_err      (to_err)
    );

    // Record every word accepted by the consumer (transfer at next posedge).
    always @(negedge sh_clk) begin
        if (!sh_rst && wd_vld && wd_rdy) got.push_back({25'b0, wd_last, wd_ch, wd_data});
    end

    task automatic step();
        @(posedge sh_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input int k, input string tag, input logic [31:0] d,
                              input logic [5:0] c, input logic l);
        logic [63:0] obs;
        obs = (k < got.size()) ? got[k] : '1;
        check(tag, obs, {25'b0, l, c, d});
    endtask

    // Drive n bits LSB first on lane ch; optionally raise done with the last bit.
    task automatic send_bits(input int ch, input logic [63:0] d, input int n, input bit done_last);
        for (int i = 0; i < n; i++) begin
            ch_out[ch]      = d[i];
            ch_out_vld[ch]  = 1'b1;
            ch_out_done[ch] = done_last && (i == n - 1);
            step();
        end
        ch_out[ch]      = 1'b0;
        ch_out_vld[ch]  = 1'b0;
        ch_out_done[ch] = 1'b0;
    endtask

    task automatic start_sweep(input logic [63:0] m);
        ch_mask = m;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_dump(input int ch, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (dump_en[ch]) break;
            step();
        end
        check(tag, dump_en, 64'(1) << ch);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            step();
        end
        check(tag, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sh_rst      = 1'b1;
        start       = 1'b0;
        ch_mask     = '0;
        ch_out      = '0;
        ch_out_vld  = '0;
        ch_out_done = '0;
        wd_rdy      = 1'b1;
        step();
        step();
        check("rst_dump_en", dump_en, 0);
        check("rst_wd_vld", wd_vld, 0);
        check("rst_wd_data", wd_data, 0);
        check("rst_wd_ch", wd_ch, 0);
        check("rst_wd_last", wd_last, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_to", to_err, 0);
        sh_rst = 1'b0;
        step();

`ifndef DUMP_BITCNT_EN
        // Zero mask: sweep ends with no output.
        got.delete();
        start_sweep(64'h0);
        step();
        step();
        check("zmask_busy", busy, 0);
        check("zmask_words", got.size(), 0);

        // 1: single channel, one full word with done on the last bit.
        got.delete();
        start_sweep(64'h1);
        wait_dump(0, "t1_dump_en");
        send_bits(0, 64'hA5A5A5A5, 32, 1'b1);
        check("t1_dump_en_off", dump_en, 0);
        check("t1_vld_latency", wd_vld, 1);
        wait_idle("t1_idle");
        check("t1_count", got.size(), 1);
        check_word(0, "t1_w0", 32'hA5A5A5A5, 6'd0, 1'b1);

        // 2: two channels, 40-bit stream then 3-bit stream.
        got.delete();
        start_sweep(64'h5);
        wait_dump(0, "t2_dump_ch0");
        send_bits(0, 64'hC3_DEADBEEF, 40, 1'b1);
        wait_dump(2, "t2_dump_ch2");
        send_bits(2, 64'h5, 3, 1'b1);
        wait_idle("t2_idle");
        check("t2_count", got.size(), 3);
        check_word(0, "t2_w0", 32'hDEADBEEF, 6'd0, 1'b0);
        check_word(1, "t2_w1", 32'h000000C3, 6'd0, 1'b1);
        check_word(2, "t2_w2", 32'h00000005, 6'd2, 1'b1);

        // 3: consumer stalled, 10 words into an 8-deep FIFO.
        got.delete();
        wd_rdy = 1'b0;
        start_sweep(64'h1);
        wait_dump(0, "t3_dump_en");
        for (int k = 0; k < 10; k++) send_bits(0, 64'(32'h10000000 + k), 32, k == 9);
        step();
        step();
        step();
        check("t3_ovf", ovf_err, 1);
        check("t3_hold_vld", wd_vld, 1);
        check("t3_hold_data", wd_data, 32'h10000000);
        check("t3_busy_full", busy, 1);
        wd_rdy = 1'b1;
        wait_idle("t3_idle");
        check("t3_count", got.size(), 8);
        for (int k = 0; k < 8; k++) check_word(k, $sformatf("t3_w%0d", k), 32'h10000000 + k, 6'd0, 1'b0);

        // 4: silent channel times out after exactly TO_CYCLES idle cycles.
        got.delete();
        start_sweep(64'h2);
        wait_dump(1, "t4_dump_en");
        for (int i = 0; i < TO_CYCLES - 1; i++) step();
        check("t4_to_before", to_err, 0);
        step();
        check("t4_to_set", to_err, 1);
        check("t4_dump_off", dump_en, 0);
        wait_idle("t4_idle");
        check("t4_count", got.size(), 1);
        check_word(0, "t4_w0", 32'h0, 6'd1, 1'b1);

        // 5: reset in the middle of a stream, then a clean sweep.
        got.delete();
        start_sweep(64'h8);
        wait_dump(3, "t5_dump_en");
        send_bits(3, 64'h2AB, 10, 1'b0);
        check("t5_to_sticky", to_err, 1);
        check("t5_ovf_sticky", ovf_err, 1);
        sh_rst = 1'b1;
        step();
        check("t5_rst_dump", dump_en, 0);
        check("t5_rst_vld", wd_vld, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_to", to_err, 0);
        check("t5_rst_ovf", ovf_err, 0);
        sh_rst = 1'b0;
        step();
        got.delete();
        start_sweep(64'h8);
        wait_dump(3, "t5_dump_again");
        send_bits(3, 64'h3C, 8, 1'b1);
        wait_idle("t5_idle");
        check("t5_count", got.size(), 1);
        check_word(0, "t5_w0", 32'h0000003C, 6'd3, 1'b1);
`else
        // 6: bit-count trailer after a 35-bit stream.
        got.delete();
        start_sweep(64'h1);
        wait_dump(0, "t6_dump_en");
        send_bits(0, 64'h5_12345678, 35, 1'b1);
        wait_idle("t6_idle");
        check("t6_count", got.size(), 3);
        check_word(0, "t6_w0", 32'h12345678, 6'd0, 1'b0);
        check_word(1, "t6_w1", 32'h00000005, 6'd0, 1'b0);
        check_word(2, "t6_trailer", 32'd35, 6'd0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
